apb_req_bridge: RTL and testbench

Parametrised APB slave front-end for the round-robin interconnect. It accepts APB transfers and queues each write or read as a request in an internal request FIFO, which is drained by the arbiter over a valid/ready port. Writes are posted. Reads are non-posted: the bridge holds the APB transfer until the arbiter returns a response or a timeout expires. Out-of-range addresses are rejected with PSLVERR.

---
 rtl/apb_req_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_apb_req_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_bridge.sv
// apb_req_bridge: APB slave front-end for the round-robin interconnect.
//
// Each APB write or read becomes one entry in a small request FIFO, which the arbiter
// drains over a valid/ready port. Writes are posted: they complete once queued. Reads
// hold the APB transfer until the arbiter returns a response or the timeout expires.
// Addresses above ADDR_LIMIT are rejected with PSLVERR and never queued.
//
// Ports
//   PCLK, PRESET          clock (rising edge) and asynchronous active-low reset
//   PSEL, PENABLE, PWRITE APB control
//   PADDR, PWDATA         APB address / write data, sampled in the access cycle
//   PRDATA, PREADY        APB read data and transfer-complete (registered)
//   PSLVERR               APB error, valid while PREADY=1 (registered)
//   req_valid/req_ready   request FIFO head handshake towards the arbiter
//   req_write/addr/wdata  FIFO head entry, presented combinationally
//   rsp_valid/rdata/err   single-cycle read response from the arbiter
//   fifo_count            current FIFO occupancy
module apb_req_bridge #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_FFFF,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       TIMEOUT    = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic                        req_write,
  output logic [ADDR_W-1:0]           req_addr,
  output logic [DATA_W-1:0]           req_wdata,
  input  logic                        rsp_valid,
  input  logic [DATA_W-1:0]           rsp_rdata,
  input  logic                        rsp_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [ToW-1:0]  ToLimit  = ToW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StWrWait,
    StRdWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              drop_q, drop_d;

  // Request FIFO
  logic              mem_write_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_wdata_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              access;
  logic              addr_bad;
  logic [DATA_W-1:0] push_wdata;

  assign access     = PSEL & PENABLE;
  assign addr_bad   = PADDR > ADDR_LIMIT;
  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign fifo_full  = (count_q == FullCnt);
  assign push_wdata = PWRITE ? PWDATA : '0;

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    to_cnt_d  = to_cnt_q;
    // Any response strobe consumes a pending drop; RD_WAIT re-arms it on timeout.
    drop_d    = drop_q & ~rsp_valid;
    push      = 1'b0;

    unique case (state_q)
      StIdle, StWrWait: begin
        // WR_WAIT re-evaluates with the APB signals the master is holding.
        if (access || (state_q == StWrWait)) begin
          if (addr_bad) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (fifo_full) begin
            state_d = StWrWait;
          end else begin
            push = 1'b1;
            if (PWRITE) begin
              state_d  = StResp;
              pready_d = 1'b1;
            end else begin
              to_cnt_d = '0;
              state_d  = StRdWait;
            end
          end
        end
      end

      StRdWait: begin
        if (rsp_valid && !drop_q) begin
          state_d   = StResp;
          pready_d  = 1'b1;
          pslverr_d = rsp_err;
          prdata_d  = rsp_rdata;
        end else begin
          // A discarded stale response counts as a cycle without a response.
          to_cnt_d = to_cnt_q + ToW'(1);
          if (to_cnt_d == ToLimit) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            drop_d    = 1'b1;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= StIdle;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      to_cnt_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      to_cnt_q  <= to_cnt_d;
      drop_q    <= drop_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  assign req_valid = (count_q != '0);
  assign pop       = req_valid & req_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through req_valid.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_write_q[wptr_q] <= PWRITE;
      mem_addr_q[wptr_q]  <= PADDR;
      mem_wdata_q[wptr_q] <= push_wdata;
    end
  end

  assign req_write  = mem_write_q[rptr_q];
  assign req_addr   = mem_addr_q[rptr_q];
  assign req_wdata  = mem_wdata_q[rptr_q];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: a vector table of single transfers, hand-written
// multi-cycle sequences (FIFO stall, read response, timeout with late response, reset
// mid-read) and a randomized phase checked against a queue-based reference model.
module tb_apb_req_bridge;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;
  localparam logic [31:0] LIMIT = 32'h0000_FFFF;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  fifo_count;

  apb_req_bridge #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ADDR_LIMIT(LIMIT),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .fifo_count(fifo_count)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_acc;
    logic [2:0]  exp_cnt;
  } vec_t;

  int          n_vec;
  int          n_bad;
  ent_t        exp_q[$];
  bit          auto_arb;
  bit          rd_pending;
  int          pend_delay;
  logic [31:0] pend_data;
  logic        pend_err;
  logic [31:0] last_data;
  logic        last_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Arbiter model: pops with random ready (always ready while a read is outstanding so
  // reads never time out here) and answers each popped read 1..5 cycles later.
  task automatic arb_step();
    ent_t e;
    rsp_valid = 1'b0;
    if (pend_delay > 0) begin
      pend_delay--;
      if (pend_delay == 0) begin
        rsp_valid = 1'b1;
        rsp_rdata = pend_data;
        rsp_err   = pend_err;
        last_data = pend_data;
        last_err  = pend_err;
      end
    end
    req_ready = rd_pending ? 1'b1 : 1'($urandom_range(0, 1));
    if (req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_when_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("rnd_pop_write", 64'(req_write), 64'(e.wr));
        check("rnd_pop_addr", 64'(req_addr), 64'(e.addr));
        check("rnd_pop_wdata", 64'(req_wdata), 64'(e.wd));
        if (!e.wr) begin
          pend_delay = int'($urandom_range(1, 5));
          pend_data  = $urandom;
          pend_err   = ($urandom_range(0, 3) == 0);
        end
      end
    end
  endtask

  // One clock: inputs for this cycle are already set; returns #1 after the edge.
  task automatic cycle();
    if (auto_arb) arb_step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int acc);
    bit done;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wd;
    cycle();
    PENABLE = 1'b1;
    acc  = 0;
    rd   = '0;
    err  = 1'b0;
    done = 1'b0;
    while (!done && acc < 300) begin
      acc++;
      if (PREADY) begin
        rd   = PRDATA;
        err  = PSLVERR;
        done = 1'b1;
      end
      cycle();
    end
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    if (!done) check("xfer_no_pready", 64'(acc), 64'd0);
  endtask

  task automatic pop_check(input string nm, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    check({nm, "_valid"}, 64'(req_valid), 64'd1);
    check({nm, "_write"}, 64'(req_write), 64'(wr));
    check({nm, "_addr"}, 64'(req_addr), 64'(a));
    check({nm, "_wdata"}, 64'(req_wdata), 64'(d));
    req_ready = 1'b1;
    cycle();
    req_ready = 1'b0;
  endtask

  task automatic apb_start(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wd;
    cycle();
    PENABLE = 1'b1;
  endtask

  task automatic apb_stop();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        tbl[5];
  logic [31:0] rd;
  logic        er;
  int          acc;

  initial begin
    n_vec = 0; n_bad = 0;
    auto_arb = 1'b0; rd_pending = 1'b0; pend_delay = 0;
    pend_data = '0; pend_err = 1'b0; last_data = '0; last_err = 1'b0;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 2, 3'd1};
    tbl[1] = '{1'b1, LIMIT + 32'd1, 32'h0000_1111, 1'b1, 1'b1, 32'h0, 2, 3'd1};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_2222, 1'b1, 1'b1, 32'h0, 2, 3'd1};
    tbl[3] = '{1'b1, LIMIT, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 2, 3'd2};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0, 2, 3'd3};

    // Reset state
    repeat (3) cycle();
    check("rst_pready", 64'(PREADY), 64'd0);
    check("rst_pslverr", 64'(PSLVERR), 64'd0);
    check("rst_prdata", 64'(PRDATA), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    PRESET = 1'b1;
    cycle();

    // Vector table, arbiter stalled
    for (int i = 0; i < 5; i++) begin
      apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, er, acc);
      check($sformatf("tbl%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
      check($sformatf("tbl%0d_acc", i), 64'(acc), 64'(tbl[i].exp_acc));
      check($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].exp_cnt));
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_prdata", i), 64'(rd), 64'(tbl[i].exp_rd));
    end
    pop_check("tbl_pop0", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    pop_check("tbl_pop1", 1'b1, LIMIT, 32'hA5A5_A5A5);
    pop_check("tbl_pop2", 1'b1, 32'h0000_0000, 32'h5A5A_5A5A);
    check("tbl_drained", 64'(fifo_count), 64'd0);

    // Five writes into a 4-deep FIFO
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), rd, er, acc);
      check($sformatf("w%0d_acc", i + 1), 64'(acc), 64'd2);
      check($sformatf("w%0d_err", i + 1), 64'(er), 64'd0);
    end
    check("w4_count", 64'(fifo_count), 64'd4);
    apb_start(1'b1, 32'h110, 32'h1004);
    for (int i = 0; i < 5; i++) begin
      check("w5_stall", 64'(PREADY), 64'd0);
      cycle();
    end
    check("w5_pop_cycle", 64'(PREADY), 64'd0);
    pop_check("w5_pop0", 1'b1, 32'h100, 32'h1000);
    check("w5_push_cycle", 64'(PREADY), 64'd0);
    cycle();
    check("w5_pready", 64'(PREADY), 64'd1);
    check("w5_pslverr", 64'(PSLVERR), 64'd0);
    check("w5_count", 64'(fifo_count), 64'd4);
    cycle();
    apb_stop();
    pop_check("w5_pop1", 1'b1, 32'h104, 32'h1001);
    pop_check("w5_pop2", 1'b1, 32'h108, 32'h1002);
    pop_check("w5_pop3", 1'b1, 32'h10C, 32'h1003);
    pop_check("w5_pop4", 1'b1, 32'h110, 32'h1004);

    // Read with response three cycles after the push
    apb_start(1'b0, 32'h20, 32'hFFFF_FFFF);
    check("rd_acc1", 64'(PREADY), 64'd0);
    cycle();
    pop_check("rd_pop", 1'b0, 32'h20, 32'h0);
    check("rd_wait2", 64'(PREADY), 64'd0);
    cycle();
    rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678; rsp_err = 1'b0;
    check("rd_wait3", 64'(PREADY), 64'd0);
    cycle();
    rsp_valid = 1'b0;
    check("rd_pready", 64'(PREADY), 64'd1);
    check("rd_prdata", 64'(PRDATA), 64'h1234_5678);
    check("rd_pslverr", 64'(PSLVERR), 64'd0);
    cycle();
    apb_stop();

    // Read timeout: 1 access cycle in IDLE, then 16 RD_WAIT cycles
    apb_start(1'b0, 32'h30, 32'h0);
    for (int i = 1; i <= 17; i++) begin
      if (i == 2) req_ready = 1'b1;
      check($sformatf("to_wait%0d", i), 64'(PREADY), 64'd0);
      cycle();
      req_ready = 1'b0;
    end
    check("to_pready", 64'(PREADY), 64'd1);
    check("to_pslverr", 64'(PSLVERR), 64'd1);
    check("to_prdata", 64'(PRDATA), 64'd0);
    cycle();
    apb_stop();
    cycle();

    // Next read: late response for the timed-out read is discarded
    apb_start(1'b0, 32'h40, 32'h0);
    cycle();
    pop_check("late_pop", 1'b0, 32'h40, 32'h0);
    rsp_valid = 1'b1; rsp_rdata = 32'hBAD0_BAD0; rsp_err = 1'b1;
    cycle();
    rsp_valid = 1'b0;
    check("late_dropped", 64'(PREADY), 64'd0);
    cycle();
    check("late_wait", 64'(PREADY), 64'd0);
    rsp_valid = 1'b1; rsp_rdata = 32'hCAFE_F00D; rsp_err = 1'b0;
    cycle();
    rsp_valid = 1'b0;
    check("late_pready", 64'(PREADY), 64'd1);
    check("late_prdata", 64'(PRDATA), 64'hCAFE_F00D);
    check("late_pslverr", 64'(PSLVERR), 64'd0);
    cycle();
    apb_stop();

    // Reset in RD_WAIT with two entries queued
    apb_xfer(1'b1, 32'h50, 32'h5050_5050, rd, er, acc);
    apb_start(1'b0, 32'h60, 32'h0);
    cycle();
    check("rst2_count_before", 64'(fifo_count), 64'd2);
    #2;
    PRESET = 1'b0;
    #1;
    check("rst2_pready", 64'(PREADY), 64'd0);
    check("rst2_count", 64'(fifo_count), 64'd0);
    check("rst2_req_valid", 64'(req_valid), 64'd0);
    apb_stop();
    cycle();
    PRESET = 1'b1;
    cycle();
    apb_xfer(1'b1, 32'h70, 32'h7070_7070, rd, er, acc);
    check("post_rst_acc", 64'(acc), 64'd2);
    check("post_rst_err", 64'(er), 64'd0);
    check("post_rst_count", 64'(fifo_count), 64'd1);
    pop_check("post_rst_pop", 1'b1, 32'h70, 32'h7070_7070);

    // Randomized traffic against the queue model
    auto_arb = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic        bad;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      wr   = 1'($urandom_range(0, 1));
      bad  = ($urandom_range(0, 7) == 0);
      addr = bad ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 32'hFFFF));
      wd   = $urandom;
      if (!bad) exp_q.push_back('{wr, addr, wr ? wd : 32'h0});
      rd_pending = !bad && !wr;
      apb_xfer(wr, addr, wd, rd, er, acc);
      rd_pending = 1'b0;
      exp_err = bad ? 1'b1 : (wr ? 1'b0 : last_err);
      exp_rd  = bad ? 32'h0 : last_data;
      check($sformatf("rnd%0d_err", n), 64'(er), 64'(exp_err));
      if (bad || !wr) check($sformatf("rnd%0d_prdata", n), 64'(rd), 64'(exp_rd));
      repeat ($urandom_range(0, 2)) cycle();
    end
    for (int i = 0; i < 200 && fifo_count != 0; i++) cycle();
    check("rnd_drain_count", 64'(fifo_count), 64'd0);
    check("rnd_model_empty", 64'(exp_q.size()), 64'd0);
    auto_arb = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
